// File: rtl/itcm_boot_loader.sv
// ---------------------------------------------------------------------------
// itcm_boot_loader
//
// Loads an rv32 program image into ITCM ahead of cpu_top.
//
// The loader takes a raw byte stream, for example from a UART or debug bridge.
// It packs the bytes little-endian into 32-bit words, so the first byte lands
// in bits [7:0]. Each word is written into the ITCM write port. After the
// image, the rest of ITCM is zero-filled. The core is held in reset until the
// whole memory has been written.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   start              one-cycle pulse that begins a load (sampled in IDLE)
//   byte_vld/byte_rdy  stream handshake; a byte moves when both are high
//   byte_data          stream byte
//   byte_last          marks the final image byte (qualified by vld&rdy)
//   itcm_cs/itcm_we    one-cycle write strobe (we mirrors cs)
//   itcm_addr          ITCM word address
//   itcm_wdata         ITCM write data
//   itcm_wem           byte write mask, all ones while writing
//   cpu_rst_n          core reset, released only once loading is done
//   busy               loading, flushing a partial word or zero-filling
//   done               image complete; core running
//   ovf                sticky: bytes arrived after ITCM was already full
// ---------------------------------------------------------------------------
module itcm_boot_loader #(
    parameter int ITCM_WORDS = 4096,
    parameter int AW         = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          byte_vld,
    output logic          byte_rdy,
    input  logic [7:0]    byte_data,
    input  logic          byte_last,
    output logic          itcm_cs,
    output logic          itcm_we,
    output logic [AW-1:0] itcm_addr,
    output logic [31:0]   itcm_wdata,
    output logic [3:0]    itcm_wem,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_ZERO  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The address counter is one bit wider than the port so that it can hold
    // ITCM_WORDS itself. That value is the "memory full" marker.
    localparam logic [AW:0] WORDS_C = (AW+1)'(ITCM_WORDS);
    localparam logic [AW:0] LAST_C  = (AW+1)'(ITCM_WORDS - 1);

    state_t        state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   word_q, word_d;
    logic [AW:0]   addr_q, addr_d;
    logic          ovf_q, ovf_d;
    logic          cs_q, cs_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cpu_rst_n_q, cpu_rst_n_d;

    logic          hs;
    logic          full;
    logic [AW:0]   addr_inc;
    logic [31:0]   word_ins;

    assign hs       = (state_q == S_LOAD) && byte_vld && rdy_q;
    assign full     = (addr_q == WORDS_C);
    assign addr_inc = addr_q + 1'b1;
    // The word register is cleared at every word boundary. OR-ing the new
    // byte into its lane therefore leaves the unfilled upper lanes at zero.
    assign word_ins = word_q | ({24'h0, byte_data} << {lane_q, 3'b000});

    // State register and all output/datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lane_q      <= 2'd0;
            word_q      <= 32'h0;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
            cs_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 32'h0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            ovf_q       <= ovf_d;
            cs_q        <= cs_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    // Next-state and byte-packing datapath
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    lane_d  = 2'd0;
                    word_d  = 32'h0;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    if (full) begin
                        // Memory already full: drain and discard the stream.
                        ovf_d = 1'b1;
                        if (byte_last) state_d = S_DONE;
                    end else if (lane_q == 2'd3) begin
                        lane_d = 2'd0;
                        word_d = 32'h0;
                        addr_d = addr_inc;
                        if (byte_last)
                            state_d = (addr_inc == WORDS_C) ? S_DONE : S_ZERO;
                    end else begin
                        lane_d = lane_q + 2'd1;
                        word_d = word_ins;
                        if (byte_last) state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                addr_d  = addr_inc;
                state_d = (addr_inc == WORDS_C) ? S_DONE : S_ZERO;
            end
            S_ZERO: begin
                addr_d = addr_inc;
                if (addr_q == LAST_C) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered-output next values
    always_comb begin
        cs_d    = 1'b0;
        waddr_d = '0;
        wdata_d = 32'h0;
        unique case (state_q)
            S_LOAD: begin
                if (hs && !full && (lane_q == 2'd3)) begin
                    cs_d    = 1'b1;
                    waddr_d = addr_q[AW-1:0];
                    wdata_d = word_ins;
                end
            end
            S_FLUSH: begin
                cs_d    = 1'b1;
                waddr_d = addr_q[AW-1:0];
                wdata_d = word_q;
            end
            S_ZERO: begin
                cs_d    = 1'b1;
                waddr_d = addr_q[AW-1:0];
                wdata_d = 32'h0;
            end
            default: begin
                cs_d = 1'b0;
            end
        endcase
        rdy_d  = (state_d == S_LOAD);
        busy_d = (state_d == S_LOAD) || (state_d == S_FLUSH) || (state_d == S_ZERO);
        // state_q enters DONE together with the final write strobe. Keying
        // done off state_q makes done and cpu_rst_n rise one cycle after that
        // final write.
        done_d      = (state_q == S_DONE);
        cpu_rst_n_d = (state_q == S_DONE);
    end

    assign byte_rdy   = rdy_q;
    assign itcm_cs    = cs_q;
    assign itcm_we    = cs_q;
    assign itcm_addr  = waddr_q;
    assign itcm_wdata = wdata_q;
    assign itcm_wem   = {4{cs_q}};
    assign cpu_rst_n  = cpu_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ovf        = ovf_q;

endmodule
